corr_score_engine: RTL and testbench
====================================

Name: corr_score_engine

Overview:
- Parametrised window-correlation engine for the camera search path.
- On a start pulse, it latches a window origin and raster-scans a WIN_W x WIN_H template against the SRAM frame, one pixel pair per clock.
- Per pixel it accumulates a similarity term (PIX_MAX - |a-b|) or a SAD term (|a-b|), selected by mode.
- Reports one score with a done pulse. Sits between the frame-SRAM read port, the search-template store and the best-match tracker.

Parameters:
- PIX_W, 10, pixel width in bits; PIX_MAX = 2^PIX_W - 1.
- WIN_W, 64, template width in pixels (>= 1).
- WIN_H, 48, template height in pixels (>= 1).
- COORD_W, 13, coordinate width.
- RD_LAT, 2, read latency in cycles from address out to data in; same for both stores; >= 1.
- SCORE_W, PIX_W + clog2(WIN_W*WIN_H), accumulator and score width; derived, do not override.

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRST_N  in  1  synchronous active-low reset.
- iStart  in  1  start request; honoured only in IDLE.
- iXstart  in  COORD_W  window origin X; sampled with an accepted iStart.
- iYstart  in  COORD_W  window origin Y; sampled with an accepted iStart.
- iMode  in  1  0 = similarity, 1 = SAD; sampled with an accepted iStart.
- oX_sram  out  COORD_W  frame read X = Xorg + x, truncated mod 2^COORD_W.
- oY_sram  out  COORD_W  frame read Y = Yorg + y, truncated mod 2^COORD_W.
- oX_search  out  COORD_W  template read X = x.
- oY_search  out  COORD_W  template read Y = y.
- oRd_valid  out  1  high on cycles in which the read addresses are live.
- iReading_sram  in  PIX_W  frame pixel; arrives RD_LAT cycles after its address.
- iReading_search  in  PIX_W  template pixel; arrives RD_LAT cycles after its address.
- oBusy  out  1  high from accepted start to the cycle before oDone.
- oDone  out  1  one-cycle pulse; oScore is final on this cycle.
- oScore  out  SCORE_W  last completed score; holds until the next oDone.

Behaviour:
- Reset: state IDLE; all outputs 0 (coordinates, oRd_valid, oBusy, oDone, oScore). Internal x, y, accumulator and valid pipeline are cleared.
- Reset mid-operation: the run is abandoned, nothing is reported, and oScore returns to 0.
- FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - iStart=1 at cycle T latches origin and mode, clears the accumulator, sets x=y=0, and moves to ISSUE.
  - oBusy rises at T+1.
- ISSUE:
  - One address per cycle, oRd_valid=1, raster order: x increments; at x=WIN_W-1 it wraps to 0 and y increments.
  - The last address (WIN_W-1, WIN_H-1) is issued at T+N, where N = WIN_W*WIN_H; the next state is DRAIN.
  - No bubbles are allowed.
- Valid pipeline: an RD_LAT-deep shift of oRd_valid marks which input cycles carry data.
- Datapath stage 1 (registered):
  - d = |sram - search|, computed at PIX_W width without sign overflow.
  - term = iMode ? d : PIX_MAX - d.
- Datapath stage 2: the accumulator adds term when stage-1 valid is set.
- Accumulator width is SCORE_W and it cannot overflow; no saturation logic.
- DRAIN: wait until the last term has been accumulated, then move to DONE.
- DONE:
  - oDone=1 and oScore=accumulator at exactly cycle T+N+RD_LAT+2; oBusy=0 in that cycle.
  - Return to IDLE next cycle.
- Coordinates hold their last values outside ISSUE; oRd_valid=0 outside ISSUE.
- iStart while not IDLE is ignored and not queued.
- iStart in the DONE cycle is ignored; iStart on the following IDLE cycle is accepted, so back-to-back runs have a 1-cycle gap.
- Origin and mode inputs may change freely after acceptance without affecting the run.
- Origin near the frame edge: the sum wraps mod 2^COORD_W; clipping is the caller's responsibility.
- WIN_W=1 or WIN_H=1: the scan must still be correct, with no off-by-one at the row wrap.

Decomposition:
- Shared package corr_pkg holds:
  - the mode encoding (CORR_SIM=0, CORR_SAD=1);
  - the FSM state enum;
  - a clog2 function;
  - default frame/template resolutions, shared with the search store.
- One sub-module: corr_pix_term (registered |a-b| and mode select, parametrised by PIX_W).
- Window counter, valid pipe and accumulator stay in the top.

Test Plan (PIX_W=10, WIN_W=4, WIN_H=2, RD_LAT=2, memory models with 2-cycle latency):
1. Start at T with (100,50), mode 0 -> oX_sram 100,101,102,103,100..103 with oY_sram 50×4 then 51×4, issued T+1..T+8. oDone at T+12.
2. Identical frame/template, mode 0 -> oScore=8184; same data, mode 1 -> oScore=0.
3. Frame all 1023, template all 0 -> mode 1 oScore=8184, mode 0 oScore=0. Frame 5, template 9 -> mode 1 oScore=32, mode 0 oScore=8152.
4. iStart pulsed at T+3 and in the DONE cycle -> ignored: one oDone only, origin unchanged. iStart at T+13 -> new run accepted, oBusy at T+14.
5. iRST_N=0 at T+5 for 1 cycle -> next cycle IDLE: oBusy=0, oRd_valid=0, oScore=0, and no oDone.
6. Origin (8190,8191), COORD_W=13 -> oX_sram 8190,8191,0,1 and oY_sram 8191 then 0. Score is unaffected by the wrap.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared definitions for the window-correlation engine and the search-template store.
package corr_pkg;

    typedef enum logic {
        CORR_SIM = 1'b0,
        CORR_SAD = 1'b1
    } corrMode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } corrState_e;

    localparam int FRAME_W_DEF = 32'sd640;
    localparam int FRAME_H_DEF = 32'sd480;
    localparam int TMPL_W_DEF  = 32'sd64;
    localparam int TMPL_H_DEF  = 32'sd48;

    // Ceiling log2; clog2(1) is 0 so a 1x1 window needs no extra score bits.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/corr_score_engine_pix_term.sv
// Registered per-pixel term: |a-b| for SAD, PIX_MAX-|a-b| for similarity.
module corr_pix_term
    import corr_pkg::*;
#(
    parameter int PIX_W = 10
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    input  corrMode_e        mode,
    input  logic [PIX_W-1:0] pixA,
    input  logic [PIX_W-1:0] pixB,
    output logic             termValid,
    output logic [PIX_W-1:0] term
);

    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

    logic [PIX_W-1:0] diff_s;
    logic [PIX_W-1:0] term_s;

    // Absolute difference ordered by compare so the subtraction never goes negative.
    always_comb begin
        diff_s = {PIX_W{1'b0}};
        term_s = {PIX_W{1'b0}};
        if (pixA >= pixB) begin
            diff_s = pixA - pixB;
        end else begin
            diff_s = pixB - pixA;
        end
        if (mode == CORR_SAD) begin
            term_s = diff_s;
        end else begin
            term_s = PIX_MAX - diff_s;
        end
    end

    // Stage-1 register for the term and its valid flag.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            termValid <= 1'b0;
            term      <= {PIX_W{1'b0}};
        end else begin
            termValid <= inValid;
            term      <= term_s;
        end
    end

endmodule

// File: rtl/corr_score_engine.sv
// Window-correlation engine: raster-scans a template against the frame and reports one score per run.
module corr_score_engine
    import corr_pkg::*;
#(
    parameter  int PIX_W   = 10,
    parameter  int WIN_W   = 64,
    parameter  int WIN_H   = 48,
    parameter  int COORD_W = 13,
    parameter  int RD_LAT  = 2,
    localparam int SCORE_W = PIX_W + clog2(WIN_W * WIN_H)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iXstart,
    input  logic [COORD_W-1:0] iYstart,
    input  logic               iMode,
    output logic [COORD_W-1:0] oX_sram,
    output logic [COORD_W-1:0] oY_sram,
    output logic [COORD_W-1:0] oX_search,
    output logic [COORD_W-1:0] oY_search,
    output logic               oRd_valid,
    input  logic [PIX_W-1:0]   iReading_sram,
    input  logic [PIX_W-1:0]   iReading_search,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCORE_W-1:0] oScore
);

    localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(WIN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(WIN_H - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};

    corrState_e         state_r;
    corrMode_e          mode_r;
    logic [COORD_W-1:0] xOrg_r;
    logic [COORD_W-1:0] yOrg_r;
    logic [RD_LAT-1:0]  vPipe_r;
    logic [SCORE_W-1:0] acc_r;
    logic [SCORE_W-1:0] accNext_s;
    logic               termValid_s;
    logic [PIX_W-1:0]   term_s;

    corr_pix_term #(
        .PIX_W (PIX_W)
    ) uPixTerm (
        .clk       (iCLK),
        .rstN      (iRST_N),
        .inValid   (vPipe_r[RD_LAT-1]),
        .mode      (mode_r),
        .pixA      (iReading_sram),
        .pixB      (iReading_search),
        .termValid (termValid_s),
        .term      (term_s)
    );

    // Next accumulator value; also feeds oScore so the final term lands in the DONE cycle.
    always_comb begin
        accNext_s = acc_r;
        if (termValid_s) begin
            accNext_s = acc_r + SCORE_W'(term_s);
        end else begin
            accNext_s = acc_r;
        end
    end

    // Scan FSM with all control and address outputs registered.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_r   <= ST_IDLE;
            mode_r    <= CORR_SIM;
            xOrg_r    <= COORD_ZERO;
            yOrg_r    <= COORD_ZERO;
            oX_sram   <= COORD_ZERO;
            oY_sram   <= COORD_ZERO;
            oX_search <= COORD_ZERO;
            oY_search <= COORD_ZERO;
            oRd_valid <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oScore    <= {SCORE_W{1'b0}};
        end else begin
            oDone <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (iStart) begin
                        state_r   <= ST_ISSUE;
                        mode_r    <= corrMode_e'(iMode);
                        xOrg_r    <= iXstart;
                        yOrg_r    <= iYstart;
                        oX_sram   <= iXstart;
                        oY_sram   <= iYstart;
                        oX_search <= COORD_ZERO;
                        oY_search <= COORD_ZERO;
                        oRd_valid <= 1'b1;
                        oBusy     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // The template counters double as the scan position.
                    if ((oX_search == LAST_X) && (oY_search == LAST_Y)) begin
                        state_r   <= ST_DRAIN;
                        oRd_valid <= 1'b0;
                    end else if (oX_search == LAST_X) begin
                        oX_search <= COORD_ZERO;
                        oY_search <= oY_search + COORD_ONE;
                        oX_sram   <= xOrg_r;
                        oY_sram   <= yOrg_r + oY_search + COORD_ONE;
                    end else begin
                        oX_search <= oX_search + COORD_ONE;
                        oX_sram   <= xOrg_r + oX_search + COORD_ONE;
                    end
                end
                ST_DRAIN: begin
                    // With no bubbles, a valid stage-1 term behind an empty read pipe is the last one.
                    if (termValid_s && (vPipe_r == {RD_LAT{1'b0}})) begin
                        state_r <= ST_DONE;
                        oDone   <= 1'b1;
                        oBusy   <= 1'b0;
                        oScore  <= accNext_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-latency shift marking which input cycles carry pixel data.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            vPipe_r <= {RD_LAT{1'b0}};
        end else begin
            vPipe_r[0] <= oRd_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                vPipe_r[i] <= vPipe_r[i-1];
            end
        end
    end

    // Score accumulator, cleared when a run is accepted.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            acc_r <= {SCORE_W{1'b0}};
        end else if ((state_r == ST_IDLE) && iStart) begin
            acc_r <= {SCORE_W{1'b0}};
        end else begin
            acc_r <= accNext_s;
        end
    end

endmodule

// File: tb/tb_corr_score_engine.sv
// Randomised and directed bench for corr_score_engine against a cycle-time reference model.
module tb_corr_score_engine;

    localparam int PIX_W    = 10;
    localparam int WIN_W    = 4;
    localparam int WIN_H    = 2;
    localparam int COORD_W  = 13;
    localparam int RD_LAT   = 2;
    localparam int N        = WIN_W * WIN_H;
    localparam int SCORE_W  = 13;
    localparam int DONE_REL = N + RD_LAT + 2;

    logic               clk = 1'b0;
    logic               rstN;
    logic               iStart;
    logic [COORD_W-1:0] iXstart;
    logic [COORD_W-1:0] iYstart;
    logic               iMode;
    logic [COORD_W-1:0] oX_sram, oY_sram, oX_search, oY_search;
    logic               oRd_valid, oBusy, oDone;
    logic [PIX_W-1:0]   rdSram, rdSearch;
    logic [SCORE_W-1:0] oScore;

    logic [PIX_W-1:0] frameMem [0:63][0:63];
    logic [PIX_W-1:0] tmplMem  [0:N-1];
    logic [PIX_W-1:0] fr1, tp1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int doneCount = 0;
    int lastDoneCyc = 0;
    int lastPulse = 0;
    bit chkEn = 1'b0;

    bit runActive = 1'b0;
    int tRun = 0;
    int rXo = 0, rYo = 0, rScore = 0;
    bit rMode = 1'b0;
    int lastScore = 0, lastXs = 0, lastYs = 0, lastXt = 0, lastYt = 0;
    int qX[$];
    int qY[$];

    corr_score_engine #(
        .PIX_W   (PIX_W),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .COORD_W (COORD_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .iCLK            (clk),
        .iRST_N          (rstN),
        .iStart          (iStart),
        .iXstart         (iXstart),
        .iYstart         (iYstart),
        .iMode           (iMode),
        .oX_sram         (oX_sram),
        .oY_sram         (oY_sram),
        .oX_search       (oX_search),
        .oY_search       (oY_search),
        .oRd_valid       (oRd_valid),
        .iReading_sram   (rdSram),
        .iReading_search (rdSearch),
        .oBusy           (oBusy),
        .oDone           (oDone),
        .oScore          (oScore)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle-latency frame and template stores.
    always @(posedge clk) begin
        fr1      <= frameMem[oX_sram[5:0]][oY_sram[5:0]];
        rdSram   <= fr1;
        tp1      <= tmplMem[{oY_search[0], oX_search[1:0]}];
        rdSearch <= tp1;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int modelScore(input int xo, input int yo, input bit m);
        int s, f, t, d;
        s = 0;
        for (int y = 0; y < WIN_H; y++) begin
            for (int x = 0; x < WIN_W; x++) begin
                f = int'(frameMem[(xo + x) & 63][(yo + y) & 63]);
                t = int'(tmplMem[y * WIN_W + x]);
                d = (f > t) ? f - t : t - f;
                s += m ? d : 1023 - d;
            end
        end
        return s;
    endfunction

    // Reference model and per-cycle compare, run mid-cycle.
    always @(negedge clk) begin : monitor
        int rel;
        bit eBusy, eRdv, eDone, idle;
        rel   = cyc - tRun;
        eBusy = runActive && rel >= 1 && rel <= DONE_REL - 1;
        eRdv  = runActive && rel >= 1 && rel <= N;
        eDone = runActive && rel == DONE_REL;
        if (eRdv) begin
            lastXt = (rel - 1) % WIN_W;
            lastYt = (rel - 1) / WIN_W;
            lastXs = (rXo + lastXt) & 8191;
            lastYs = (rYo + lastYt) & 8191;
            qX.push_back(lastXs);
            qY.push_back(lastYs);
        end
        if (eDone) lastScore = rScore;
        if (oDone === 1'b1) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
        if (chkEn) begin
            chk("busy", int'(oBusy), int'(eBusy));
            chk("rdValid", int'(oRd_valid), int'(eRdv));
            chk("done", int'(oDone), int'(eDone));
            chk("score", int'(oScore), lastScore);
            chk("xSram", int'(oX_sram), lastXs);
            chk("ySram", int'(oY_sram), lastYs);
            chk("xSearch", int'(oX_search), lastXt);
            chk("ySearch", int'(oY_search), lastYt);
        end
        if (!rstN) begin
            runActive = 1'b0;
            lastScore = 0; lastXs = 0; lastYs = 0; lastXt = 0; lastYt = 0;
            chkEn = 1'b1;
        end else begin
            idle = !runActive || rel >= DONE_REL + 1;
            if (runActive && rel >= DONE_REL) runActive = 1'b0;
            if (iStart && idle) begin
                rXo = int'(iXstart);
                rYo = int'(iYstart);
                rMode = iMode;
                rScore = modelScore(rXo, rYo, rMode);
                tRun = cyc;
                runActive = 1'b1;
            end
        end
    end

    task automatic pulseAt(input int c, input int xo, input int yo, input bit m);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
        iXstart = COORD_W'(xo);
        iYstart = COORD_W'(yo);
        iMode = m;
        iStart = 1'b1;
        lastPulse = cyc;
        @(posedge clk); #1;
        iStart = 1'b0;
        iXstart = COORD_W'($urandom);
        iYstart = COORD_W'($urandom);
        iMode = 1'($urandom);
    endtask

    task automatic waitDone();
        int d0, n;
        d0 = doneCount;
        n = 0;
        while (doneCount == d0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("doneSeen", int'(doneCount != d0), 1);
    endtask

    task automatic setIdentical(input int xo, input int yo);
        int v;
        for (int i = 0; i < N; i++) begin
            v = $urandom_range(0, 1023);
            tmplMem[i] = PIX_W'(v);
            frameMem[(xo + i % WIN_W) & 63][(yo + i / WIN_W) & 63] = PIX_W'(v);
        end
    endtask

    task automatic fillConst(input int fv, input int tv);
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++) frameMem[i][j] = PIX_W'(fv);
        for (int i = 0; i < N; i++) tmplMem[i] = PIX_W'(tv);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++) frameMem[i][j] = PIX_W'($urandom_range(0, 1023));
        for (int i = 0; i < N; i++) tmplMem[i] = PIX_W'($urandom_range(0, 1023));
    endtask

    task automatic runLit(input string name, input int xo, input int yo, input bit m, input int lit);
        pulseAt(cyc, xo, yo, m);
        waitDone();
        chk(name, rScore, lit);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, d0;
        int expX[8];
        int expY[8];
        int wrapX[8];
        int wrapY[8];
        expX  = '{100, 101, 102, 103, 100, 101, 102, 103};
        expY  = '{50, 50, 50, 50, 51, 51, 51, 51};
        wrapX = '{8190, 8191, 0, 1, 8190, 8191, 0, 1};
        wrapY = '{8191, 8191, 8191, 8191, 0, 0, 0, 0};
        rstN = 1'b0; iStart = 1'b0; iXstart = '0; iYstart = '0; iMode = 1'b0;
        fillRandom();
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk); #1;

        // Scan order, latency and identical data.
        setIdentical(100, 50);
        qX.delete(); qY.delete();
        pulseAt(cyc, 100, 50, 1'b0);
        t0 = lastPulse;
        waitDone();
        chk("doneLatency", lastDoneCyc - t0, 12);
        chk("model_sim_identical", rScore, 8184);
        chk("addrCount", qX.size(), 8);
        for (int i = 0; i < 8 && i < qX.size(); i++) begin
            chk("addrX", qX[i], expX[i]);
            chk("addrY", qY[i], expY[i]);
        end
        runLit("model_sad_identical", 100, 50, 1'b1, 0);

        // Extreme and constant data.
        fillConst(1023, 0);
        runLit("model_sad_extreme", 100, 50, 1'b1, 8184);
        runLit("model_sim_extreme", 100, 50, 1'b0, 0);
        fillConst(5, 9);
        runLit("model_sad_const", 300, 200, 1'b1, 32);
        runLit("model_sim_const", 300, 200, 1'b0, 8152);

        // Stray starts mid-run and in the DONE cycle, then back-to-back accept.
        setIdentical(100, 50);
        pulseAt(cyc, 100, 50, 1'b0);
        t0 = lastPulse;
        d0 = doneCount;
        pulseAt(t0 + 3, 7, 7, 1'b1);
        pulseAt(t0 + 12, 9, 9, 1'b1);
        pulseAt(t0 + 13, 100, 50, 1'b1);
        waitDone();
        chk("doneCountStray", doneCount - d0, 2);
        chk("backToBackDone", lastDoneCyc, t0 + 25);
        chk("model_sad_identical2", rScore, 0);

        // Reset mid-run.
        pulseAt(cyc, 100, 50, 1'b0);
        t0 = lastPulse;
        d0 = doneCount;
        while (cyc < t0 + 5) begin
            @(posedge clk); #1;
        end
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("noDoneAfterReset", doneCount - d0, 0);

        // Coordinate wrap at the frame edge.
        fillRandom();
        qX.delete(); qY.delete();
        pulseAt(cyc, 8190, 8191, 1'($urandom));
        waitDone();
        chk("wrapAddrCount", qX.size(), 8);
        for (int i = 0; i < 8 && i < qX.size(); i++) begin
            chk("wrapX", qX[i], wrapX[i]);
            chk("wrapY", qY[i], wrapY[i]);
        end

        // Random runs with random gaps and stray starts.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 2) == 0) fillRandom();
            pulseAt(cyc + $urandom_range(0, 2), $urandom_range(0, 8191), $urandom_range(0, 8191),
                    1'($urandom));
            if ($urandom_range(0, 1) == 1)
                pulseAt(lastPulse + $urandom_range(1, 11), $urandom_range(0, 8191),
                        $urandom_range(0, 8191), 1'($urandom));
            waitDone();
        end
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
